byte_run_controller: RTL and testbench
======================================

Name: byte_run_controller

Overview:
- Sequencer and memory arbiter for the 8-bit accumulator CPU and its 32x8 single-port program/data memory.
- Loads a program from a host byte stream, runs the CPU until it halts, then streams memory contents back to the host.
- Owns the only memory port and muxes it between the host side and the CPU, so the two never access memory at the same time.

Parameters:
- AW, 5, memory address width; depth = 2^AW.
- DW, 8, data width.
- TIMEOUT, 1000, RUN cycle limit (used only with WATCHDOG_EN); range 1..65535.

Ports:
- clk  in  1  clock
- rst_n  in  1  reset: synchronous, active-low
- load_req  in  1  start-LOAD pulse (sampled in IDLE only)
- load_len  in  AW+1  bytes to load; 0 means 2^AW; sampled with load_req
- run_req  in  1  start-RUN pulse (IDLE only)
- dump_req  in  1  start-DUMP pulse (IDLE only)
- in_valid  in  1  load stream valid
- in_ready  out  1  load stream ready
- in_data  in  DW  load byte
- out_valid  out  1  dump stream valid
- out_ready  in  1  dump stream ready
- out_data  out  DW  dump byte
- busy  out  1  high whenever state != IDLE
- done  out  1  one-cycle pulse on return to IDLE from any operation
- timeout  out  1  sticky; set by watchdog abort, cleared by next run_req
- run_cycles  out  16  RUN cycle count, saturating; held after RUN
- cpu_start  out  1  to CPU start
- cpu_halt  in  1  from CPU halt
- cpu_we  in  1  CPU write enable
- cpu_addr  in  AW  CPU address
- cpu_wdata  in  DW  CPU store data
- cpu_rdata  out  DW  to CPU read data (= mem_rdata)
- mem_we  out  1  memory write enable
- mem_addr  out  AW  memory address
- mem_wdata  out  DW  memory write data
- mem_rdata  in  DW  memory read data, combinational (async read)

Behaviour:
- States: IDLE, LOAD, RUN, DUMP. Reset (rst_n low at a clk edge) forces IDLE from any state, including mid-LOAD, mid-RUN and mid-DUMP.
- Reset values: ptr=0, run_cycles=0, timeout=0; in_ready, out_valid, busy, done, cpu_start and mem_we all 0. Memory contents are not touched.
- IDLE: request priority when several are high in the same cycle is load_req > run_req > dump_req; lower-priority requests are dropped. Each accepted request sets ptr=0.
- LOAD:
  - in_ready=1.
  - On in_valid&in_ready: mem_we=1, mem_addr=ptr, mem_wdata=in_data, ptr++.
  - After load_len bytes: go to IDLE and pulse done.
  - ptr wraps modulo 2^AW; it only reaches a full wrap when len = 2^AW.
- RUN:
  - The memory port is muxed combinationally to the CPU: mem_we=cpu_we, mem_addr=cpu_addr, mem_wdata=cpu_wdata. cpu_rdata always equals mem_rdata.
  - cpu_start=1 for the whole of RUN.
  - run_cycles is cleared on entry and increments each RUN cycle, saturating at 0xFFFF.
  - When cpu_halt=1 is sampled: cpu_start drops on the next cycle, state returns to IDLE, done pulses.
  - cpu_start stays low for at least 1 cycle in IDLE before any re-entry to RUN, so the CPU returns to its reset state.
- Outside RUN: cpu_we is ignored and cpu_start=0.
- DUMP:
  - out_valid=1, out_data=mem_rdata at mem_addr=ptr, mem_we=0.
  - On out_valid&out_ready: ptr++.
  - out_data stays stable while stalled.
  - After the handshake of byte 2^AW-1: go to IDLE, pulse done.
- Any requests that arrive while busy are ignored.
- done is registered: it is high for exactly the first IDLE cycle after LOAD, RUN or DUMP.

Optional Feature:
- Macro WATCHDOG_EN.
- When defined:
  - If run_cycles reaches TIMEOUT in RUN without cpu_halt, abort: cpu_start=0, state to IDLE, done pulses, timeout=1.
  - If halt and TIMEOUT occur on the same cycle, halt wins and timeout stays 0.
- When undefined:
  - RUN waits for cpu_halt indefinitely.
  - The timeout output is tied to 0 and TIMEOUT is unused.

Test Plan:
- LOAD len=3, bytes 0x81,0x42,0xFF, with in_valid gaps -> mem[0..2] hold those values, done pulses once, in_ready is low after completion.
- LOAD len=0 with 32 bytes 0x00..0x1F, then DUMP with out_ready toggling 1/0 -> out_data sequence 0x00..0x1F, no byte duplicated or lost, out_data stable during stalls.
- RUN with a CPU model that asserts cpu_halt after 17 cycles and writes 0x5A to addr 9 -> mem[9]=0x5A, run_cycles=17, cpu_start low the cycle after halt, done pulses.
- load_req and run_req in the same IDLE cycle -> LOAD entered; run_req is ignored; cpu_start stays 0.
- rst_n low during LOAD after 2 of 5 bytes, and again during RUN -> IDLE next edge, all outputs at reset values, the 2 written bytes preserved.
- WATCHDOG_EN, TIMEOUT=50, CPU never halts -> abort at run_cycles=50, timeout=1; next run_req clears timeout.

Source files
------------

// File: rtl/byte_run_controller.sv
// byte_run_controller: sequencer and memory arbiter for the 8-bit accumulator CPU.
// The host loads a program byte stream into memory, the CPU runs until it halts, then memory
// is streamed back out. This block owns the single memory port and muxes it between the host
// stream (LOAD/DUMP) and the CPU (RUN).
// Optional feature: define WATCHDOG_EN to abort a RUN that lasts TIMEOUT cycles without a halt.
module byte_run_controller #(
  parameter int unsigned AW      = 5,
  parameter int unsigned DW      = 8,
  parameter int unsigned TIMEOUT = 1000
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          load_req,
  input  logic [AW:0]   load_len,
  input  logic          run_req,
  input  logic          dump_req,
  input  logic          in_valid,
  output logic          in_ready,
  input  logic [DW-1:0] in_data,
  output logic          out_valid,
  input  logic          out_ready,
  output logic [DW-1:0] out_data,
  output logic          busy,
  output logic          done,
  output logic          timeout,
  output logic [15:0]   run_cycles,
  output logic          cpu_start,
  input  logic          cpu_halt,
  input  logic          cpu_we,
  input  logic [AW-1:0] cpu_addr,
  input  logic [DW-1:0] cpu_wdata,
  output logic [DW-1:0] cpu_rdata,
  output logic          mem_we,
  output logic [AW-1:0] mem_addr,
  output logic [DW-1:0] mem_wdata,
  input  logic [DW-1:0] mem_rdata
);

  typedef enum logic [1:0] {StIdle, StLoad, StRun, StDump} state_e;

  // load_len of zero encodes a full-memory load.
  localparam logic [AW:0]   FullLen     = {1'b1, {AW{1'b0}}};
  localparam logic [AW-1:0] PtrLast     = {AW{1'b1}};
  localparam logic [15:0]   TimeoutLast = 16'(TIMEOUT - 1);

`ifdef WATCHDOG_EN
  localparam bit WdEn = 1'b1;
`else
  localparam bit WdEn = 1'b0;
`endif

  state_e        state_q, state_d;
  logic [AW-1:0] ptr_q, ptr_d;
  logic [AW:0]   rem_q, rem_d;
  logic [15:0]   run_cycles_q, run_cycles_d;
  logic          done_q;

  logic load_go, run_go, dump_go, in_fire, out_fire, wd_abort;

  // Request decode: load beats run beats dump; anything outside IDLE is dropped.
  assign load_go  = (state_q == StIdle) && load_req;
  assign run_go   = (state_q == StIdle) && !load_req && run_req;
  assign dump_go  = (state_q == StIdle) && !load_req && !run_req && dump_req;
  assign in_fire  = (state_q == StLoad) && in_valid;
  assign out_fire = (state_q == StDump) && out_ready;

  // This RUN cycle is the TIMEOUT-th one; a simultaneous halt takes precedence.
  assign wd_abort = WdEn && (state_q == StRun) && !cpu_halt && (run_cycles_q == TimeoutLast);

  // Next-state, pointer, remaining-length and cycle-counter logic.
  always_comb begin
    state_d      = state_q;
    ptr_d        = ptr_q;
    rem_d        = rem_q;
    run_cycles_d = run_cycles_q;
    case (state_q)
      StIdle: begin
        if (load_go) begin
          state_d = StLoad;
          ptr_d   = '0;
          rem_d   = (load_len == '0) ? FullLen : load_len;
        end else if (run_go) begin
          state_d      = StRun;
          ptr_d        = '0;
          run_cycles_d = '0;
        end else if (dump_go) begin
          state_d = StDump;
          ptr_d   = '0;
        end
      end
      StLoad: begin
        if (in_fire) begin
          ptr_d = ptr_q + AW'(1);
          rem_d = rem_q - (AW+1)'(1);
          if (rem_q == (AW+1)'(1)) state_d = StIdle;
        end
      end
      StRun: begin
        if (run_cycles_q != 16'hFFFF) run_cycles_d = run_cycles_q + 16'd1;
        if (cpu_halt || wd_abort) state_d = StIdle;
      end
      StDump: begin
        if (out_fire) begin
          ptr_d = ptr_q + AW'(1);
          if (ptr_q == PtrLast) state_d = StIdle;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  // State registers with synchronous active-low reset; memory contents live outside.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q      <= StIdle;
      ptr_q        <= '0;
      rem_q        <= '0;
      run_cycles_q <= '0;
      done_q       <= 1'b0;
    end else begin
      state_q      <= state_d;
      ptr_q        <= ptr_d;
      rem_q        <= rem_d;
      run_cycles_q <= run_cycles_d;
      done_q       <= (state_q != StIdle) && (state_d == StIdle);
    end
  end

`ifdef WATCHDOG_EN
  logic timeout_q;

  // Sticky abort flag, cleared only when the next RUN is accepted.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      timeout_q <= 1'b0;
    end else if (run_go) begin
      timeout_q <= 1'b0;
    end else if (wd_abort) begin
      timeout_q <= 1'b1;
    end
  end

  assign timeout = timeout_q;
`else
  assign timeout = 1'b0;
`endif

  // Memory port mux: CPU owns it during RUN, the host streams use ptr otherwise.
  always_comb begin
    mem_we    = 1'b0;
    mem_addr  = ptr_q;
    mem_wdata = in_data;
    if (state_q == StRun) begin
      mem_we    = cpu_we;
      mem_addr  = cpu_addr;
      mem_wdata = cpu_wdata;
    end else if (state_q == StLoad) begin
      mem_we = in_valid;
    end
  end

  assign in_ready   = (state_q == StLoad);
  assign out_valid  = (state_q == StDump);
  assign out_data   = mem_rdata;
  assign cpu_rdata  = mem_rdata;
  assign cpu_start  = (state_q == StRun);
  assign busy       = (state_q != StIdle);
  assign done       = done_q;
  assign run_cycles = run_cycles_q;

endmodule

// File: tb/tb_byte_run_controller.sv
// Testbench for byte_run_controller: bench-side 32x8 async-read memory, a transaction-level
// expectation model updated by the stimulus tasks, and a per-cycle compare process.
module tb_byte_run_controller;
  localparam int unsigned AW      = 5;
  localparam int unsigned DW      = 8;
  localparam int unsigned TIMEOUT = 50;
  localparam int          DEPTH   = 32;
`ifdef WATCHDOG_EN
  localparam bit WD = 1'b1;
`else
  localparam bit WD = 1'b0;
`endif

  logic          clk, rst_n;
  logic          load_req, run_req, dump_req;
  logic [AW:0]   load_len;
  logic          in_valid, in_ready, out_valid, out_ready;
  logic [DW-1:0] in_data, out_data;
  logic          busy, done, timeout;
  logic [15:0]   run_cycles;
  logic          cpu_start, cpu_halt, cpu_we;
  logic [AW-1:0] cpu_addr, mem_addr;
  logic [DW-1:0] cpu_wdata, cpu_rdata, mem_wdata, mem_rdata;
  logic          mem_we;

  byte_run_controller #(.AW(AW), .DW(DW), .TIMEOUT(TIMEOUT)) dut (
    .clk(clk), .rst_n(rst_n), .load_req(load_req), .load_len(load_len), .run_req(run_req),
    .dump_req(dump_req), .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data), .busy(busy),
    .done(done), .timeout(timeout), .run_cycles(run_cycles), .cpu_start(cpu_start),
    .cpu_halt(cpu_halt), .cpu_we(cpu_we), .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata),
    .cpu_rdata(cpu_rdata), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_rdata(mem_rdata)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Environment memory driven by the DUT port.
  logic [7:0] mem [DEPTH];
  always @(posedge clk) if (mem_we) mem[mem_addr] <= mem_wdata;
  assign mem_rdata = mem[mem_addr];

  int checks, errors;
  bit chk_en;

  // Expectation model.
  logic        exp_busy, exp_in_ready, exp_out_valid, exp_cpu_start, exp_done, exp_timeout;
  logic        exp_mem_we;
  logic [15:0] exp_run_cycles;
  logic [4:0]  exp_addr;
  logic [7:0]  exp_wdata;
  int          exp_ptr;
  logic [7:0]  ref_mem [DEPTH];
  bit          ref_ok [DEPTH];
  logic [7:0]  ld_data [DEPTH];
  logic [7:0]  dumped [$];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h at %0t", name, act, req, $time);
    end
  endtask

  // Per-cycle comparison against the model, away from the active edge.
  always @(negedge clk) begin
    if (chk_en) begin
      chk("busy", busy, exp_busy);
      chk("in_ready", in_ready, exp_in_ready);
      chk("out_valid", out_valid, exp_out_valid);
      chk("cpu_start", cpu_start, exp_cpu_start);
      chk("done", done, exp_done);
      chk("timeout", timeout, exp_timeout);
      chk("run_cycles", run_cycles, exp_run_cycles);
      chk("mem_we", mem_we, exp_mem_we);
      if (exp_mem_we) begin
        chk("mem_addr", mem_addr, exp_addr);
        chk("mem_wdata", mem_wdata, exp_wdata);
      end
      if (exp_out_valid) begin
        chk("dump_addr", mem_addr, exp_ptr);
        if (ref_ok[exp_ptr]) chk("out_data", out_data, ref_mem[exp_ptr]);
      end
      if (exp_cpu_start) begin
        chk("run_addr", mem_addr, cpu_addr);
        if (ref_ok[cpu_addr]) chk("cpu_rdata", cpu_rdata, ref_mem[cpu_addr]);
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic quiet();
    load_req = 0; run_req = 0; dump_req = 0; load_len = '0; in_valid = 0; in_data = '0;
    out_ready = 0; cpu_halt = 0; cpu_we = 0; cpu_addr = '0; cpu_wdata = '0;
  endtask

  task automatic stray();
    load_req = 1'($urandom_range(0, 1));
    run_req  = 1'($urandom_range(0, 1));
    dump_req = 1'($urandom_range(0, 1));
  endtask

  task automatic set_idle_exp(input logic d);
    exp_busy = 0; exp_in_ready = 0; exp_out_valid = 0; exp_cpu_start = 0; exp_mem_we = 0;
    exp_done = d;
  endtask

  // Hold reset for one edge during a busy cycle; the operation is abandoned.
  task automatic reset_cycle();
    quiet();
    exp_mem_we = 0;
    rst_n = 0;
    step();
    rst_n = 1;
    set_idle_exp(0);
    exp_run_cycles = '0;
    exp_timeout = 0;
  endtask

  task automatic idle_cycles(input int n);
    for (int c = 0; c < n; c++) begin
      quiet();
      cpu_we = 1'($urandom_range(0, 1)); cpu_addr = 5'($urandom); cpu_wdata = 8'($urandom);
      cpu_halt = 1'($urandom_range(0, 1)); in_valid = 1'($urandom_range(0, 1));
      in_data = 8'($urandom); out_ready = 1'($urandom_range(0, 1));
      step();
      set_idle_exp(0);
    end
  endtask

  // LOAD of len bytes from ld_data; rst_after >= 0 resets once that many bytes are in.
  task automatic do_load(input int len, input bit gaps, input bit others, input int rst_after);
    int n, i, guard;
    bit v;
    quiet();
    load_req = 1; load_len = (AW+1)'(len);
    if (others) begin run_req = 1; dump_req = 1'($urandom_range(0, 1)); end
    step();
    n = (len == 0) ? DEPTH : len;
    i = 0;
    exp_busy = 1; exp_in_ready = 1; exp_done = 0;
    for (guard = 0; guard < 4000; guard++) begin
      if (i == rst_after) begin
        reset_cycle();
        return;
      end
      v = gaps ? ($urandom_range(0, 2) != 0) : 1'b1;
      stray();
      in_valid = v; in_data = ld_data[i];
      exp_mem_we = v; exp_addr = 5'(i); exp_wdata = ld_data[i];
      step();
      if (v) begin
        ref_mem[i] = ld_data[i];
        ref_ok[i] = 1;
        i++;
      end
      if (i == n) begin
        quiet();
        set_idle_exp(1);
        return;
      end
    end
    checks++; errors++;
    $display("FAIL load_bound actual=%0d bytes required=%0d", i, n);
    reset_cycle();
  endtask

  // RUN with a CPU that halts on RUN cycle halt_after (0 = never) and stores on wr_cycle.
  task automatic run_cpu(input int halt_after, input int wr_cycle, input logic [4:0] wa,
                         input logic [7:0] wd, input bit with_dump, input int rst_at);
    int k;
    bit we, fin;
    quiet();
    run_req = 1; dump_req = with_dump;
    step();
    exp_busy = 1; exp_cpu_start = 1; exp_done = 0; exp_timeout = 0; exp_run_cycles = '0;
    for (k = 1; k <= 3000; k++) begin
      if (k == rst_at) begin
        reset_cycle();
        return;
      end
      stray();
      we = (k == wr_cycle);
      cpu_halt = (k == halt_after);
      cpu_we = we;
      cpu_addr = we ? wa : 5'($urandom);
      cpu_wdata = we ? wd : 8'($urandom);
      exp_mem_we = we; exp_addr = cpu_addr; exp_wdata = cpu_wdata;
      fin = cpu_halt || (WD && k == TIMEOUT);
      step();
      if (we) begin
        ref_mem[wa] = wd;
        ref_ok[wa] = 1;
      end
      if (fin) begin
        exp_timeout = WD && (k == TIMEOUT) && (k != halt_after);
        quiet();
        set_idle_exp(1);
        exp_run_cycles = 16'(k);
        return;
      end
      exp_run_cycles = 16'(k);
    end
    checks++; errors++;
    $display("FAIL run_bound actual=%0d cycles required=halt", k);
    reset_cycle();
  endtask

  // DUMP the whole memory; mode 0 toggles out_ready 1/0, mode 1 randomises it.
  task automatic do_dump(input bit mode);
    bit r, t;
    int guard;
    quiet();
    dump_req = 1;
    step();
    dumped.delete();
    exp_busy = 1; exp_out_valid = 1; exp_ptr = 0; exp_done = 0; exp_mem_we = 0;
    t = 1;
    for (guard = 0; guard < 4000; guard++) begin
      r = mode ? 1'($urandom_range(0, 1)) : t;
      t = !t;
      stray();
      out_ready = r;
      cpu_we = 1'($urandom_range(0, 1)); cpu_addr = 5'($urandom);
      @(negedge clk);
      if (r) dumped.push_back(out_data);
      step();
      if (r) begin
        exp_ptr++;
        if (exp_ptr == DEPTH) begin
          quiet();
          set_idle_exp(1);
          return;
        end
      end
    end
    checks++; errors++;
    $display("FAIL dump_bound actual=%0d bytes required=%0d", exp_ptr, DEPTH);
    reset_cycle();
  endtask

  int op, len;

  initial begin
    checks = 0; errors = 0; chk_en = 0;
    for (int j = 0; j < DEPTH; j++) begin ref_mem[j] = '0; ref_ok[j] = 0; ld_data[j] = '0; end
    quiet();
    rst_n = 0;
    step(); step();
    rst_n = 1;
    set_idle_exp(0);
    exp_run_cycles = '0; exp_timeout = 0; exp_ptr = 0; exp_addr = '0; exp_wdata = '0;
    chk_en = 1;
    idle_cycles(2);

    // Short load with gaps.
    ld_data[0] = 8'h81; ld_data[1] = 8'h42; ld_data[2] = 8'hFF;
    do_load(3, 1, 0, -1);
    idle_cycles(2);
    chk("t1_mem0", mem[0], 8'h81);
    chk("t1_mem1", mem[1], 8'h42);
    chk("t1_mem2", mem[2], 8'hFF);

    // Full load (len 0) issued together with run_req, then stalled dump.
    for (int j = 0; j < DEPTH; j++) ld_data[j] = 8'(j);
    do_load(0, 1, 1, -1);
    idle_cycles(1);
    do_dump(0);
    chk("t2_dump_count", dumped.size(), DEPTH);
    for (int j = 0; j < DEPTH && j < dumped.size(); j++) chk("t2_dump_byte", dumped[j], 8'(j));

    // CPU halts after 17 cycles having stored 0x5A at address 9.
    idle_cycles(1);
    run_cpu(17, 5, 5'd9, 8'h5A, 1, 0);
    chk("t3_run_cycles", run_cycles, 16'd17);
    idle_cycles(1);
    chk("t3_mem9", mem[9], 8'h5A);

    // Reset mid-LOAD after 2 of 5 bytes, then mid-RUN.
    for (int j = 0; j < 5; j++) ld_data[j] = 8'hA0 + 8'(j);
    do_load(5, 0, 0, 2);
    chk("t4_mem0", mem[0], 8'hA0);
    chk("t4_mem1", mem[1], 8'hA1);
    chk("t4_mem2", mem[2], 8'h02);
    idle_cycles(2);
    run_cpu(40, 0, 5'd0, 8'h00, 0, 10);
    chk("t4_run_cycles", run_cycles, 16'd0);
    idle_cycles(2);

`ifdef WATCHDOG_EN
    // CPU never halts: watchdog abort, then cleared by the next run; then halt/timeout tie.
    run_cpu(0, 0, 5'd0, 8'h00, 0, 0);
    chk("t6_timeout", timeout, 1'b1);
    chk("t6_run_cycles", run_cycles, 16'd50);
    idle_cycles(1);
    run_cpu(3, 0, 5'd0, 8'h00, 0, 0);
    chk("t6_cleared", timeout, 1'b0);
    run_cpu(0, 0, 5'd0, 8'h00, 0, 0);
    idle_cycles(1);
    run_cpu(50, 0, 5'd0, 8'h00, 0, 0);
    chk("t6_tie", timeout, 1'b0);
`endif

    // Randomised mix of operations.
    for (int it = 0; it < 30; it++) begin
      op = $urandom_range(0, 2);
      idle_cycles($urandom_range(0, 3));
      case (op)
        0: begin
          len = $urandom_range(0, 32);
          for (int j = 0; j < DEPTH; j++) ld_data[j] = 8'($urandom);
          do_load(len, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), -1);
        end
        1: run_cpu($urandom_range(1, 60), $urandom_range(0, 20), 5'($urandom), 8'($urandom),
                   1'($urandom_range(0, 1)), 0);
        default: do_dump(1'($urandom_range(0, 1)));
      endcase
    end
    idle_cycles(3);

    chk_en = 0;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
